branch_target_buffer: RTL and testbench

//  Responder side of the fetch-stage BTB port. Consumes npc/stall from the fetch stage.

---
 rtl/branch_target_buffer.sv | 144 ++++++++++++++
 tb/tb_branch_target_buffer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer with 2-bit saturating counters.
// One-cycle registered lookup for fetch, write-first training from execute.
module branch_target_buffer #(
  parameter int PC_WIDTH  = 32,
  parameter int ENTRY_NUM = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] npc,
  input  logic                stall,
  output logic                btbHit,
  output logic [PC_WIDTH-1:0] btbPredictedPc,
  input  logic                updateEn,
  input  logic [PC_WIDTH-1:0] updatePc,
  input  logic [PC_WIDTH-1:0] updateTarget,
  input  logic                updateTaken
);

  localparam int INDEX_W = $clog2(ENTRY_NUM);
  localparam int TAG_W   = PC_WIDTH - INDEX_W - 2;

  logic [ENTRY_NUM-1:0] valid_r;
  logic [TAG_W-1:0]     tag_r    [ENTRY_NUM];
  logic [PC_WIDTH-1:0]  target_r [ENTRY_NUM];
  logic [1:0]           ctr_r    [ENTRY_NUM];

  logic                hit_r;
  logic [PC_WIDTH-1:0] predPc_r;

  logic [INDEX_W-1:0]  updIdx_s;
  logic [TAG_W-1:0]    updTag_s;
  logic                updHit_s;
  logic                wrEn_s;
  logic [PC_WIDTH-1:0] newTarget_s;
  logic [1:0]          newCtr_s;

  logic [INDEX_W-1:0]  lkIdx_s;
  logic [TAG_W-1:0]    lkTagQ_s;
  logic                bypass_s;
  logic                lkValid_s;
  logic [TAG_W-1:0]    lkTag_s;
  logic [PC_WIDTH-1:0] lkTarget_s;
  logic [1:0]          lkCtr_s;
  logic                lkHit_s;
  logic [PC_WIDTH-1:0] lkPc_s;

  // Word alignment makes the two low PC bits irrelevant.
  logic unusedBits_s;
  assign unusedBits_s = ^{npc[1:0], updatePc[1:0]};

  assign updIdx_s = updatePc[INDEX_W+1:2];
  assign updTag_s = updatePc[PC_WIDTH-1:INDEX_W+2];
  assign updHit_s = valid_r[updIdx_s] && (tag_r[updIdx_s] == updTag_s);
  assign lkIdx_s  = npc[INDEX_W+1:2];
  assign lkTagQ_s = npc[PC_WIDTH-1:INDEX_W+2];

  // Training decision: the post-update entry contents for the update index.
  always_comb begin
    wrEn_s      = 1'b0;
    newTarget_s = target_r[updIdx_s];
    newCtr_s    = ctr_r[updIdx_s];
    if (updateEn) begin
      if (!updHit_s) begin
        if (updateTaken) begin
          wrEn_s      = 1'b1;
          newTarget_s = updateTarget;
          newCtr_s    = 2'd2;
        end else begin
          wrEn_s = 1'b0;
        end
      end else begin
        wrEn_s = 1'b1;
        if (updateTaken) begin
          newTarget_s = updateTarget;
          newCtr_s    = (ctr_r[updIdx_s] == 2'd3) ? 2'd3 : ctr_r[updIdx_s] + 2'd1;
        end else begin
          newCtr_s    = (ctr_r[updIdx_s] == 2'd0) ? 2'd0 : ctr_r[updIdx_s] - 2'd1;
        end
      end
    end else begin
      wrEn_s = 1'b0;
    end
  end

  // Lookup sees the entry as it will be after this cycle's training (write-first).
  always_comb begin
    bypass_s = wrEn_s && (updIdx_s == lkIdx_s);
    if (bypass_s) begin
      lkValid_s  = 1'b1;
      lkTag_s    = updTag_s;
      lkTarget_s = newTarget_s;
      lkCtr_s    = newCtr_s;
    end else begin
      lkValid_s  = valid_r[lkIdx_s];
      lkTag_s    = tag_r[lkIdx_s];
      lkTarget_s = target_r[lkIdx_s];
      lkCtr_s    = ctr_r[lkIdx_s];
    end
    lkHit_s = lkValid_s && (lkTag_s == lkTagQ_s) && lkCtr_s[1];
    if (lkHit_s) begin
      lkPc_s = lkTarget_s;
    end else begin
      lkPc_s = {PC_WIDTH{1'b0}};
    end
  end

  // Valid bits are the only table state that reset must clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= {ENTRY_NUM{1'b0}};
    end else if (wrEn_s) begin
      valid_r[updIdx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag/target/counter payload; contents are don't-care until the entry is valid.
  always_ff @(posedge clk) begin
    if (wrEn_s) begin
      tag_r[updIdx_s]    <= updTag_s;
      target_r[updIdx_s] <= newTarget_s;
      ctr_r[updIdx_s]    <= newCtr_s;
    end
  end

  // Registered lookup result, frozen while fetch is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_r    <= 1'b0;
      predPc_r <= {PC_WIDTH{1'b0}};
    end else if (!stall) begin
      hit_r    <= lkHit_s;
      predPc_r <= lkPc_s;
    end else begin
      hit_r    <= hit_r;
      predPc_r <= predPc_r;
    end
  end

  assign btbHit         = hit_r;
  assign btbPredictedPc = predPc_r;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural BTB model computed from the index/tag/counter rules.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic        stall;
  logic        btbHit;
  logic [31:0] btbPredictedPc;
  logic        updateEn;
  logic [31:0] updatePc;
  logic [31:0] updateTarget;
  logic        updateTaken;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          mValid  [64];
  int unsigned mTag    [64];
  int unsigned mTarget [64];
  int          mCtr    [64];
  bit          expHit;
  int unsigned expPc;

  branch_target_buffer #(.PC_WIDTH(32), .ENTRY_NUM(64)) dut (
    .clk(clk), .rst(rst), .npc(npc), .stall(stall),
    .btbHit(btbHit), .btbPredictedPc(btbPredictedPc),
    .updateEn(updateEn), .updatePc(updatePc),
    .updateTarget(updateTarget), .updateTaken(updateTaken)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
    expHit = 1'b0;
    expPc  = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    int unsigned ui, ut, li, lt;
    bit hit;
    if (!rst) begin
      modelClear();
      return;
    end
    ui  = (updatePc >> 2) % 64;
    ut  = updatePc >> 8;
    hit = mValid[ui] && (mTag[ui] == ut);
    if (updateEn) begin
      if (!hit) begin
        if (updateTaken) begin
          mValid[ui] = 1'b1; mTag[ui] = ut; mTarget[ui] = updateTarget; mCtr[ui] = 2;
        end
      end else if (updateTaken) begin
        mCtr[ui] = (mCtr[ui] + 1 > 3) ? 3 : mCtr[ui] + 1;
        mTarget[ui] = updateTarget;
      end else begin
        mCtr[ui] = (mCtr[ui] - 1 < 0) ? 0 : mCtr[ui] - 1;
      end
    end
    if (!stall) begin
      li     = (npc >> 2) % 64;
      lt     = npc >> 8;
      expHit = mValid[li] && (mTag[li] == lt) && (mCtr[li] >= 2);
      expPc  = expHit ? mTarget[li] : 0;
    end
  endtask

  // One clock: step the model, then compare DUT outputs 1ns after the edge.
  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    check("hit", {31'd0, btbHit}, {31'd0, expHit});
    check("pc", btbPredictedPc, expPc);
  endtask

  task automatic setUpd(input logic en, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    updateEn = en; updatePc = pc; updateTarget = tgt; updateTaken = tk;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic req, input logic [31:0] reqPc, input string name);
    npc = pc; stall = 1'b0; setUpd(1'b0, 32'd0, 32'd0, 1'b0);
    cycle();
    check({name, "_model_hit"}, {31'd0, expHit}, {31'd0, req});
    check({name, "_hit"}, {31'd0, btbHit}, {31'd0, req});
    check({name, "_pc"}, btbPredictedPc, reqPc);
  endtask

  initial begin
    rst = 1'b0; npc = 32'd0; stall = 1'b0;
    setUpd(1'b0, 32'd0, 32'd0, 1'b0);
    modelClear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_hit", {31'd0, btbHit}, 32'd0);
    check("reset_pc", btbPredictedPc, 32'd0);
    rst = 1'b1;

    // 1: lookup after reset misses
    for (int i = 0; i < 3; i++) lookup(32'h100, 1'b0, 32'h0, "t1");

    // 2: allocate and hit
    npc = 32'h104; setUpd(1'b1, 32'h100, 32'h400, 1'b1); cycle();
    lookup(32'h100, 1'b1, 32'h400, "t2");

    // 3: hysteresis 2->1 misses, 1->2 hits again
    npc = 32'h104; setUpd(1'b1, 32'h100, 32'h400, 1'b0); cycle();
    lookup(32'h100, 1'b0, 32'h0, "t3_weak");
    npc = 32'h104; setUpd(1'b1, 32'h100, 32'h400, 1'b1); cycle();
    lookup(32'h100, 1'b1, 32'h400, "t3_strong");

    // 4: alias eviction on index 0
    npc = 32'h104; setUpd(1'b1, 32'h200, 32'h800, 1'b1); cycle();
    lookup(32'h100, 1'b0, 32'h0, "t4_old");
    lookup(32'h200, 1'b1, 32'h800, "t4_new");

    // 5: stall holds outputs while npc moves, table still trains
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      npc = 32'h100 + 32'(i) * 32'h4;
      setUpd(i == 1, 32'h108, 32'h900, 1'b1);
      cycle();
      check("t5_hold_hit", {31'd0, btbHit}, 32'd1);
      check("t5_hold_pc", btbPredictedPc, 32'h800);
    end
    stall = 1'b0;
    npc = 32'h300; setUpd(1'b1, 32'h300, 32'hC00, 1'b1); cycle();
    check("t5_bypass_hit", {31'd0, btbHit}, 32'd1);
    check("t5_bypass_pc", btbPredictedPc, 32'hC00);
    lookup(32'h108, 1'b1, 32'h900, "t5_trained");

    // 6: async reset between edges
    #2 rst = 1'b0;
    #1;
    check("t6_async_hit", {31'd0, btbHit}, 32'd0);
    check("t6_async_pc", btbPredictedPc, 32'd0);
    modelClear();
    @(posedge clk); #1;
    rst = 1'b1;
    lookup(32'h100, 1'b0, 32'h0, "t6_a");
    lookup(32'h300, 1'b0, 32'h0, "t6_b");
    lookup(32'h108, 1'b0, 32'h0, "t6_c");

    // Randomized traffic over a small address window to force hits and aliasing
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pa, pb;
      pa = ($urandom_range(3) << 8) | ($urandom_range(7) << 2) | $urandom_range(3);
      pb = ($urandom_range(3) << 8) | ($urandom_range(7) << 2) | $urandom_range(3);
      if ($urandom_range(3) == 0) pb = pa;
      npc   = pa;
      stall = ($urandom_range(4) == 0);
      setUpd($urandom_range(1) == 1, pb, $urandom & 32'hFFFF_FFFC, $urandom_range(9) < 7);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
